// File: rtl/imm_extend_pkg.sv
// Shared core definitions: immediate-format select encoding used by the
// control decoder and the immediate generator.
package imm_extend_pkg;

    localparam int unsigned XLEN = 32;

    // Immediate format select values (ImmSrc)
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/imm_extend.sv
// RV32I immediate generator for the decode stage. Produces the extended
// immediate combinationally (ImmExtD) and a registered copy for execute (ImmExtE).
module imm_extend
    import imm_extend_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [31:7]       InstrD,
    input  logic [2:0]        ImmSrcD,
    output logic [XLEN-1:0]   ImmExtD,
    output logic [XLEN-1:0]   ImmExtE
);

    logic sign;

    assign sign = InstrD[31];

    // Format decode; reserved encodings give zero so no X ever leaves the block.
    always_comb begin
        ImmExtD = '0;
        case (ImmSrcD)
            IMM_I:   ImmExtD = {{20{sign}}, InstrD[31:20]};
            IMM_S:   ImmExtD = {{20{sign}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   ImmExtD = {{20{sign}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   ImmExtD = {{12{sign}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            IMM_U:   ImmExtD = {InstrD[31:12], 12'b0};
            default: ImmExtD = '0;
        endcase
    end

    // Decode-to-execute pipeline register; reset clears only this copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            ImmExtE <= '0;
        end else begin
            ImmExtE <= ImmExtD;
        end
    end

endmodule

// File: tb/tb_imm_extend.sv
// Self-checking bench for imm_extend: table-driven format vectors plus
// hand-written reset and pipeline sequences.
module tb_imm_extend;

    logic        clock;
    logic        reset;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] imm_ext_d;
    logic [31:0] imm_ext_e;

    int checks;
    int errors;

    imm_extend dut (
        .clock   (clock),
        .reset   (reset),
        .InstrD  (instr),
        .ImmSrcD (imm_src),
        .ImmExtD (imm_ext_d),
        .ImmExtE (imm_ext_e)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [24:0] instr;
        logic [2:0]  src;
        logic [31:0] exp;
    } vec_t;

    localparam logic [24:0] PAT  = 25'b0010111110111100101001001;
    localparam logic [24:0] ONES = 25'h1FF_FFFF;
    localparam logic [24:0] SGN  = 25'h100_0000;
    localparam int NVEC = 23;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // PAT: I=2FB, S=2E9, B=AE8, U=2FBCA000.
        // J re-derived field by field: imm[19:12]=CA, imm[11]=1, imm[10:1]=0x17D -> 000CAAFA.
        vecs[0]  = '{PAT,  3'd0, 32'h0000_02FB};
        vecs[1]  = '{PAT,  3'd1, 32'h0000_02E9};
        vecs[2]  = '{PAT,  3'd2, 32'h0000_0AE8};
        vecs[3]  = '{PAT,  3'd3, 32'h000C_AAFA};
        vecs[4]  = '{PAT,  3'd4, 32'h2FBC_A000};
        vecs[5]  = '{PAT,  3'd5, 32'h0000_0000};
        vecs[6]  = '{PAT,  3'd6, 32'h0000_0000};
        vecs[7]  = '{PAT,  3'd7, 32'h0000_0000};
        vecs[8]  = '{ONES, 3'd0, 32'hFFFF_FFFF};
        vecs[9]  = '{ONES, 3'd1, 32'hFFFF_FFFF};
        vecs[10] = '{ONES, 3'd2, 32'hFFFF_FFFE};
        vecs[11] = '{ONES, 3'd3, 32'hFFFF_FFFE};
        vecs[12] = '{ONES, 3'd4, 32'hFFFF_F000};
        vecs[13] = '{ONES, 3'd7, 32'h0000_0000};
        // Only the sign bit set: checks sign-extension widths per format
        vecs[14] = '{SGN,  3'd0, 32'hFFFF_F800};
        vecs[15] = '{SGN,  3'd1, 32'hFFFF_F800};
        vecs[16] = '{SGN,  3'd2, 32'hFFFF_F000};
        vecs[17] = '{SGN,  3'd3, 32'hFFF0_0000};
        vecs[18] = '{SGN,  3'd4, 32'h8000_0000};
        // Single low bits: B takes bit 7 as imm[11], J takes bit 20 as imm[11]
        vecs[19] = '{25'h000_0001, 3'd2, 32'h0000_0800};
        vecs[20] = '{25'h000_0001, 3'd1, 32'h0000_0001};
        vecs[21] = '{25'h000_2000, 3'd3, 32'h0000_0800};
        vecs[22] = '{25'h000_0000, 3'd0, 32'h0000_0000};

        reset   = 1'b1;
        instr   = PAT;
        imm_src = 3'd0;

        // Reset held for two edges clears the registered copy
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_e", imm_ext_e, 32'h0);
        check("reset_d_tracks", imm_ext_d, 32'h0000_02FB);

        // Release with I-type; the register picks it up one edge later
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_e_before_edge", imm_ext_e, 32'h0);
        @(posedge clock);
        #1;
        check("release_e", imm_ext_e, 32'h0000_02FB);

        // Table: combinational result immediately, registered result next edge
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            instr   = vecs[i].instr;
            imm_src = vecs[i].src;
            #1;
            check($sformatf("vec%0d_d", i), imm_ext_d, vecs[i].exp);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_e", i), imm_ext_e, vecs[i].exp);
        end

        // Format change with InstrD held: D moves at once, E waits for the edge
        @(negedge clock);
        instr   = PAT;
        imm_src = 3'd0;
        @(posedge clock);
        @(negedge clock);
        imm_src = 3'd4;
        #1;
        check("src_change_d", imm_ext_d, 32'h2FBC_A000);
        check("src_change_e_hold", imm_ext_e, 32'h0000_02FB);
        @(posedge clock);
        #1;
        check("src_change_e", imm_ext_e, 32'h2FBC_A000);

        // Mid-run reset clears only the register
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_e", imm_ext_e, 32'h0);
        check("midrst_d", imm_ext_d, 32'h2FBC_A000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_recover_e", imm_ext_e, 32'h2FBC_A000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
